// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four requesters share one DATA_W-bit output channel.
// Round-robin grant with burst lock, MAX_BURST fairness cap, one idle
// bubble between grants, and valid/ready flow control on both sides.
module mux4_rr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        in_valid,
  input  logic [3:0]        in_last,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        mux_flag,
  output logic [3:0]        grant,
  output logic              busy,
  output logic              burst_cut
);

  // Counter only needs to reach MAX_BURST-1; a one-bit counter covers MAX_BURST=1.
  localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_r;
  logic [1:0]          lastPtr_r;
  logic [CNT_W-1:0]    beatCnt_r;

  logic [1:0]          winner_s;
  logic [3:0]          winnerOh_s;
  logic [DATA_W-1:0]   selData_s;
  logic                selValid_s;
  logic                selLast_s;
  logic                capHit_s;
  logic                xfer_s;

  // First requesting index after ptr, wrapping; ptr itself has lowest priority.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx  = ptr + 2'(k);
      pick = req[idx] ? idx : pick;
    end
    return pick;
  endfunction

  function automatic logic [3:0] toOneHot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Steer the selected requester's data bus onto the output channel.
  always_comb begin
    selData_s = in_data0;
    case (mux_flag)
      2'd0:    selData_s = in_data0;
      2'd1:    selData_s = in_data1;
      2'd2:    selData_s = in_data2;
      2'd3:    selData_s = in_data3;
      default: selData_s = in_data0;
    endcase
  end

  // Arbitration winner and handshake decode for the granted requester.
  always_comb begin
    winner_s   = rrPick(in_valid, lastPtr_r);
    winnerOh_s = toOneHot(winner_s);
    selValid_s = in_valid[mux_flag];
    selLast_s  = in_last[mux_flag];
    capHit_s   = (beatCnt_r == CNT_LAST);
    if (state_r == BUSY) begin
      out_valid = selValid_s;
      in_ready  = toOneHot(mux_flag) & {4{out_ready}};
    end else begin
      out_valid = 1'b0;
      in_ready  = 4'b0000;
    end
    xfer_s = out_valid & out_ready;
  end

  assign out_data = selData_s;
  assign busy     = (state_r == BUSY);

  // Grant sequencer: arbitrate in IDLE, count beats and release in BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      grant     <= 4'b0000;
      mux_flag  <= 2'b00;
      lastPtr_r <= 2'd3;
      beatCnt_r <= '0;
      burst_cut <= 1'b0;
    end else begin
      burst_cut <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|in_valid) begin
            state_r   <= BUSY;
            grant     <= winnerOh_s;
            mux_flag  <= winner_s;
            beatCnt_r <= '0;
          end
        end
        BUSY: begin
          if (xfer_s) begin
            if (selLast_s || capHit_s) begin
              // mux_flag is left as-is; it is a don't-care while idle.
              state_r   <= IDLE;
              grant     <= 4'b0000;
              lastPtr_r <= mux_flag;
              beatCnt_r <= '0;
              burst_cut <= ~selLast_s;
            end else begin
              beatCnt_r <= beatCnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          grant   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (MAX_BURST=4). Requester models
// present queued beats; expected beats go into a scoreboard queue when
// stimulus is queued and are compared as the output channel transfers.
module tb_mux4_rr_arbiter;

  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic [3:0]    in_valid  = 4'b0000;
  logic [3:0]    in_last   = 4'b0000;
  logic [DW-1:0] inData [4];
  logic [3:0]    in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    mux_flag;
  logic [3:0]    grant;
  logic          busy;
  logic          burst_cut;

  int         nChecks  = 0;
  int         nPass    = 0;
  int         xferCnt  = 0;
  int         cutCnt   = 0;
  logic       sbEn     = 1'b0;
  logic [3:0] xferMask = 4'b0000;
  logic [3:0] pulseV   = 4'b0000;
  logic [3:0] pulseL   = 4'b0000;
  logic [32:0] srcQ [4][$];
  logic [33:0] expQ [$];

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (inData[0]),
    .in_data1  (inData[1]),
    .in_data2  (inData[2]),
    .in_data3  (inData[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mux_flag  (mux_flag),
    .grant     (grant),
    .busy      (busy),
    .burst_cut (burst_cut)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic addBeat(input int src, input logic [31:0] data, input logic last);
    srcQ[src].push_back({last, data});
    expQ.push_back({2'(src), data});
  endtask

  task automatic applySources();
    for (int i = 0; i < 4; i++) begin
      if (srcQ[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_last[i]  = srcQ[i][0][32];
        inData[i]   = srcQ[i][0][31:0];
      end else begin
        in_valid[i] = pulseV[i];
        in_last[i]  = pulseL[i];
        inData[i]   = 32'hDEAD_0000 | 32'(i);
      end
    end
  endtask

  function automatic int srcLeft();
    int s = 0;
    for (int i = 0; i < 4; i++) s += srcQ[i].size();
    return s;
  endfunction

  // Called at a negedge; checks outputs while reset is held.
  task automatic doReset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) srcQ[i].delete();
    expQ.delete();
    pulseV    = 4'b0000;
    pulseL    = 4'b0000;
    out_ready = 1'b1;
    applySources();
    #1;
    checkVal("rst_grant",     64'(grant),     64'd0);
    checkVal("rst_mux_flag",  64'(mux_flag),  64'd0);
    checkVal("rst_busy",      64'(busy),      64'd0);
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_in_ready",  64'(in_ready),  64'd0);
    checkVal("rst_burst_cut", 64'(burst_cut), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || expQ.size() != 0 || srcLeft() != 0) && n < budget);
    checkVal(tag, 64'(!busy && expQ.size() == 0 && srcLeft() == 0), 64'd1);
  endtask

  // Burst on requester 0 with out_ready pattern 1,0,0,1,1,1 from the grant cycle.
  task automatic runStalled(input int nb, input logic [31:0] seed);
    logic [5:0] pat;
    int base;
    int cut0;
    pat  = 6'b111001;
    base = xferCnt;
    cut0 = cutCnt;
    for (int k = 0; k < nb; k++) addBeat(0, seed + 32'(k), k == nb - 1);
    applySources();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      out_ready = (k < 6) ? pat[k] : 1'b1;
      @(negedge clk);
      if (busy && !out_ready) begin
        checkVal("t4_stall_data",  64'(out_data),  64'(seed + 32'd1));
        checkVal("t4_stall_valid", 64'(out_valid), 64'd1);
        checkVal("t4_stall_ready", 64'(in_ready),  64'd0);
      end
    end
    checkVal("t4_xfers",  64'(xferCnt - base), 64'(nb));
    checkVal("t4_no_cut", 64'(cutCnt - cut0),  64'd0);
    checkVal("t4_idle",   64'(busy),           64'd0);
  endtask

  // Output monitor: scoreboard compare on every transfer, sideband counters.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      xferMask = reset_n ? (in_valid & in_ready) : 4'b0000;
      if (reset_n && out_valid && out_ready) begin
        xferCnt++;
        if (sbEn) begin
          if (expQ.size() == 0) begin
            checkVal("unexpected_beat", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkVal("beat_data", 64'(out_data), 64'(e[31:0]));
            checkVal("beat_sel",  64'(mux_flag), 64'(e[33:32]));
          end
        end
      end
      if (reset_n && burst_cut) cutCnt++;
    end
  end

  // Requester models: retire accepted beats and present the next one.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (xferMask[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      end
      applySources();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cut0;
    int n;
    int busyCyc;
    int firstB;
    int lastB;

    // 1: reset, abandon a burst by reset, then a single 3-beat burst
    @(negedge clk);
    doReset();
    sbEn = 1'b0;
    for (int k = 0; k < 6; k++) addBeat(1, 32'h5000 + 32'(k), 1'b0);
    applySources();
    repeat (3) @(negedge clk);
    checkVal("t1_pre_busy", 64'(busy), 64'd1);
    doReset();
    sbEn = 1'b1;
    addBeat(1, 32'hA0, 1'b0);
    addBeat(1, 32'hA1, 1'b0);
    addBeat(1, 32'hA2, 1'b1);
    applySources();
    base = xferCnt;
    @(negedge clk);
    checkVal("t1_not_yet", 64'(grant), 64'd0);
    @(negedge clk);
    checkVal("t1_grant",    64'(grant),    64'b0010);
    checkVal("t1_mux_flag", 64'(mux_flag), 64'b01);
    checkVal("t1_busy",     64'(busy),     64'd1);
    waitIdle("t1_done", 20);
    checkVal("t1_xfers", 64'(xferCnt - base), 64'd3);

    // 2: round-robin fairness from reset, 1-beat bursts on all four
    doReset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) addBeat(s, 32'hB000 + 32'(r * 16 + s), 1'b1);
    applySources();
    busyCyc = 0;
    firstB  = -1;
    lastB   = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin
        busyCyc++;
        if (firstB < 0) firstB = k;
        lastB = k;
      end
    end
    checkVal("t2_busy_cycles", 64'(busyCyc),       64'd8);
    checkVal("t2_span",        64'(lastB - firstB), 64'd14);
    checkVal("t2_drain",       64'(expQ.size()),   64'd0);

    // 3: forced release at MAX_BURST, pending requester 3 served next
    @(posedge clk); #2;
    base = xferCnt;
    cut0 = cutCnt;
    for (int k = 0; k < 4; k++) addBeat(2, 32'hE00 + 32'(k), 1'b0);
    addBeat(3, 32'hE3F, 1'b1);
    for (int k = 4; k < 10; k++) addBeat(2, 32'hE00 + 32'(k), k == 9);
    applySources();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!burst_cut && n < 20);
    checkVal("t3_cut_seen",  64'(burst_cut),      64'd1);
    checkVal("t3_pre_cut",   64'(xferCnt - base), 64'd4);
    checkVal("t3_cut_idle",  64'(busy),           64'd0);
    @(negedge clk);
    checkVal("t3_cut_pulse", 64'(burst_cut), 64'd0);
    checkVal("t3_next",      64'(grant),     64'b1000);
    waitIdle("t3_done", 40);
    checkVal("t3_cut_total", 64'(cutCnt - cut0),  64'd2);
    checkVal("t3_xfers",     64'(xferCnt - base), 64'd11);

    // 4: backpressure; a 4-beat run also shows beat count frozen in stalls
    @(posedge clk); #2;
    runStalled(2, 32'hC0);
    @(posedge clk); #2;
    runStalled(4, 32'hD0);

    // 5: pointer wrap after serving requester 3
    @(posedge clk); #2;
    addBeat(3, 32'h33, 1'b1);
    applySources();
    waitIdle("t5_pre", 10);
    @(posedge clk); #2;
    addBeat(0, 32'h50, 1'b1);
    addBeat(3, 32'h53, 1'b1);
    applySources();
    @(negedge clk);
    @(negedge clk);
    checkVal("t5_grant",    64'(grant),    64'b0001);
    checkVal("t5_mux_flag", 64'(mux_flag), 64'b00);
    waitIdle("t5_done", 10);

    // 6: sideband from a non-granted requester is ignored
    @(posedge clk); #2;
    base = xferCnt;
    addBeat(1, 32'hF0, 1'b0);
    addBeat(1, 32'hF1, 1'b0);
    addBeat(1, 32'hF2, 1'b1);
    applySources();
    @(posedge clk); #2;
    @(posedge clk); #2;
    pulseV = 4'b0001;
    pulseL = 4'b0001;
    applySources();
    @(negedge clk);
    checkVal("t6_ready0", 64'(in_ready[0]), 64'd0);
    checkVal("t6_grant",  64'(grant),       64'b0010);
    checkVal("t6_busy",   64'(busy),        64'd1);
    @(posedge clk); #2;
    pulseV = 4'b0000;
    pulseL = 4'b0000;
    applySources();
    @(negedge clk);
    checkVal("t6_held", 64'(busy), 64'd1);
    waitIdle("t6_done", 20);
    checkVal("t6_xfers", 64'(xferCnt - base), 64'd3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
